// File: rtl/fpu_issue_unit_if.sv
// Issue-queue handshake bundle between decode, the FPU hazard unit and fpu_issue_unit.
// Optional stall_count_o signal is present only when FPU_ISSUE_STATS_EN is defined.
interface fpu_issue_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] instr_i;
    logic             instr_valid_i;
    logic             instr_ready_o;
    logic             flush_i;
    logic             hazard_i;
    logic [WIDTH-1:0] fpu_instr_o;
    logic             execute_o;
    logic             stall_o;
`ifdef FPU_ISSUE_STATS_EN
    logic [15:0]      stall_count_o;

    modport master (
        output instr_i, instr_valid_i, flush_i, hazard_i,
        input  instr_ready_o, fpu_instr_o, execute_o, stall_o, stall_count_o
    );
    modport slave (
        input  instr_i, instr_valid_i, flush_i, hazard_i,
        output instr_ready_o, fpu_instr_o, execute_o, stall_o, stall_count_o
    );
`else
    modport master (
        output instr_i, instr_valid_i, flush_i, hazard_i,
        input  instr_ready_o, fpu_instr_o, execute_o, stall_o
    );
    modport slave (
        input  instr_i, instr_valid_i, flush_i, hazard_i,
        output instr_ready_o, fpu_instr_o, execute_o, stall_o
    );
`endif
endinterface

// File: rtl/fpu_issue_unit.sv
// In-order FPU issue queue: DEPTH-entry FIFO whose head issues unless a RAW hazard blocks it.
// Define FPU_ISSUE_STATS_EN to add a saturating 16-bit stall-cycle counter (stall_count_o).
module fpu_issue_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    fpu_issue_unit_if.slave  bus
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             not_empty;
    logic             ready;
    logic             push;
    logic             pop;

    // Handshake and issue decisions; ready looks at registered occupancy only.
    always_comb begin
        not_empty         = (count_q != '0);
        ready             = (count_q != Full);
        push              = bus.instr_valid_i && ready && !bus.flush_i;
        pop               = not_empty && !bus.hazard_i && !bus.flush_i;
        bus.instr_ready_o = ready;
        bus.execute_o     = pop;
        bus.stall_o       = not_empty && bus.hazard_i && !bus.flush_i;
        bus.fpu_instr_o   = not_empty ? mem_q[rd_ptr_q] : '0;
    end

    // Pointer/occupancy next state; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue control state; reset wins over flush, push and pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.instr_i;
        end
    end

`ifdef FPU_ISSUE_STATS_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles the head sat blocked by a hazard.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (bus.stall_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall_count_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fpu_issue_unit.sv
// Self-checking bench for fpu_issue_unit (WIDTH=32, DEPTH=2): directed vector table,
// a scoreboard-checked streaming sequence, and the stall counter when FPU_ISSUE_STATS_EN is set.
module tb_fpu_issue_unit;
    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] instr;
        logic        flush;
        logic        hazard;
        logic        ready;
        logic        exec;
        logic        stall;
        logic [31:0] fpu;
    } vec_t;

    logic clk = 1'b0;
    logic rst_i;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];

    fpu_issue_unit_if #(.WIDTH(32)) bus ();

    fpu_issue_unit #(
        .WIDTH (32),
        .DEPTH (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic valid, input logic [31:0] instr,
                       input logic flush, input logic hazard, input logic ready,
                       input logic exec, input logic stall, input logic [31:0] fpu);
        vec_t v;
        v.rst = rst; v.valid = valid; v.instr = instr; v.flush = flush; v.hazard = hazard;
        v.ready = ready; v.exec = exec; v.stall = stall; v.fpu = fpu;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic ready, input logic exec,
                         input logic stall, input logic [31:0] fpu);
        n_vec++;
        if (bus.instr_ready_o !== ready || bus.execute_o !== exec ||
            bus.stall_o !== stall || bus.fpu_instr_o !== fpu) begin
            n_err++;
            $display("FAIL %s: got ready=%b exec=%b stall=%b fpu=%h, want ready=%b exec=%b stall=%b fpu=%h",
                     name, bus.instr_ready_o, bus.execute_o, bus.stall_o, bus.fpu_instr_o,
                     ready, exec, stall, fpu);
        end
    endtask

    initial begin
        logic [31:0] model[$];
        logic [31:0] next_id;
        logic        hz, exp_rdy, exp_ex;
        logic [31:0] exp_fpu;

        //  rst v  instr          fl hz  rdy ex st fpu
        add(0, 0, 32'h0,          0, 0,  1, 0, 0, 32'h0);           // reset state
        add(0, 1, 32'h0000_1234,  0, 0,  1, 0, 0, 32'h0);           // push, no bypass
        add(0, 0, 32'h0,          0, 0,  1, 1, 0, 32'h0000_1234);   // issue
        add(0, 0, 32'h0,          0, 0,  1, 0, 0, 32'h0);           // empty again
        add(0, 1, 32'hAAAA_0001,  0, 1,  1, 0, 0, 32'h0);           // push A, hazard ignored
        add(0, 1, 32'hBBBB_0002,  0, 1,  1, 0, 1, 32'hAAAA_0001);   // push B, stall on A
        add(0, 1, 32'hCCCC_0003,  0, 1,  0, 0, 1, 32'hAAAA_0001);   // full, C held off
        add(0, 1, 32'hCCCC_0003,  0, 1,  0, 0, 1, 32'hAAAA_0001);
        add(0, 0, 32'h0,          0, 0,  0, 1, 0, 32'hAAAA_0001);   // release: A
        add(0, 0, 32'h0,          0, 0,  1, 1, 0, 32'hBBBB_0002);   // then B
        add(0, 0, 32'h0,          0, 0,  1, 0, 0, 32'h0);
        add(0, 1, 32'h0000_0011,  0, 1,  1, 0, 0, 32'h0);           // fill X1
        add(0, 1, 32'h0000_0022,  0, 1,  1, 0, 1, 32'h0000_0011);   // fill X2
        add(0, 1, 32'h0000_0033,  0, 0,  0, 1, 0, 32'h0000_0011);   // full: pop, X3 ignored
        add(0, 1, 32'h0000_0033,  0, 0,  1, 1, 0, 32'h0000_0022);   // push+pop
        add(0, 1, 32'h0000_0044,  0, 0,  1, 1, 0, 32'h0000_0033);   // push+pop
        add(0, 0, 32'h0,          0, 0,  1, 1, 0, 32'h0000_0044);
        add(0, 0, 32'h0,          0, 0,  1, 0, 0, 32'h0);
        add(0, 1, 32'h0000_00A1,  0, 1,  1, 0, 0, 32'h0);           // Y1
        add(0, 1, 32'h0000_00A2,  0, 1,  1, 0, 1, 32'h0000_00A1);   // Y2
        add(0, 1, 32'h0000_00DD,  1, 0,  0, 0, 0, 32'h0000_00A1);   // flush while pushing D
        add(0, 0, 32'h0,          0, 0,  1, 0, 0, 32'h0);           // flushed
        add(0, 0, 32'h0,          0, 0,  1, 0, 0, 32'h0);           // D never appears
        add(0, 1, 32'h0000_00E1,  0, 1,  1, 0, 0, 32'h0);
        add(0, 1, 32'h0000_00F2,  0, 1,  1, 0, 1, 32'h0000_00E1);
        add(1, 1, 32'h0000_0077,  1, 1,  0, 0, 0, 32'h0000_00E1);   // reset+flush+push
        add(0, 0, 32'h0,          0, 1,  1, 0, 0, 32'h0);           // reset values
        add(0, 1, 32'h0000_0088,  0, 0,  1, 0, 0, 32'h0);
        add(0, 0, 32'h0,          0, 0,  1, 1, 0, 32'h0000_0088);
        add(0, 0, 32'h0,          0, 0,  1, 0, 0, 32'h0);
        add(0, 1, 32'h0000_0099,  0, 1,  1, 0, 0, 32'h0);
        add(0, 1, 32'h0000_009A,  0, 1,  1, 0, 1, 32'h0000_0099);
        add(1, 0, 32'h0,          0, 1,  0, 0, 1, 32'h0000_0099);   // reset mid-stall
        add(0, 0, 32'h0,          0, 0,  1, 0, 0, 32'h0);           // nothing issues

        rst_i = 1'b1;
        bus.instr_i = '0; bus.instr_valid_i = 1'b0; bus.flush_i = 1'b0; bus.hazard_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_i             = vecs[i].rst;
            bus.instr_valid_i = vecs[i].valid;
            bus.instr_i       = vecs[i].instr;
            bus.flush_i       = vecs[i].flush;
            bus.hazard_i      = vecs[i].hazard;
            #1;
            check($sformatf("vec%0d", i), vecs[i].ready, vecs[i].exec, vecs[i].stall,
                  vecs[i].fpu);
            @(negedge clk);
        end

        // Streaming with a periodic hazard against a FIFO scoreboard; wraps pointers often.
        rst_i = 1'b0; bus.flush_i = 1'b0; bus.instr_valid_i = 1'b1;
        next_id = 32'h5000_0000;
        for (int c = 0; c < 40; c++) begin
            hz           = (c % 3 == 0);
            bus.hazard_i = hz;
            bus.instr_i  = next_id;
            #1;
            exp_rdy = (model.size() != 2);
            exp_ex  = (model.size() != 0) && !hz;
            exp_fpu = (model.size() != 0) ? model[0] : 32'h0;
            check($sformatf("stream%0d", c), exp_rdy, exp_ex,
                  (model.size() != 0) && hz, exp_fpu);
            if (exp_ex) void'(model.pop_front());
            if (exp_rdy) begin
                model.push_back(next_id);
                next_id = next_id + 32'd1;
            end
            @(negedge clk);
        end
        bus.instr_valid_i = 1'b0; bus.hazard_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;

`ifdef FPU_ISSUE_STATS_EN
        #1;
        n_vec++;
        if (bus.stall_count_o !== 16'h0) begin
            n_err++;
            $display("FAIL stat_reset: got %h want 0000", bus.stall_count_o);
        end
        @(negedge clk);
        bus.instr_valid_i = 1'b1; bus.instr_i = 32'h0000_5A5A; bus.hazard_i = 1'b1;
        @(negedge clk);
        bus.instr_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (bus.stall_count_o !== 16'd3) begin
            n_err++;
            $display("FAIL stat_three: got %h want 0003", bus.stall_count_o);
        end
        repeat (70000) @(negedge clk);
        #1;
        n_vec++;
        if (bus.stall_count_o !== 16'hFFFF) begin
            n_err++;
            $display("FAIL stat_sat: got %h want ffff", bus.stall_count_o);
        end
        check("stat_still_stalled", 1'b1, 1'b0, 1'b1, 32'h0000_5A5A);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0; bus.hazard_i = 1'b0;
        #1;
        n_vec++;
        if (bus.stall_count_o !== 16'h0) begin
            n_err++;
            $display("FAIL stat_clear: got %h want 0000", bus.stall_count_o);
        end
        check("stat_after_reset", 1'b1, 1'b0, 1'b0, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fpu_issue_unit.md
FPU_ISSUE_UNIT -- requirements
Module: fpu_issue_unit

Interface
REQ-001 Parameter WIDTH, default 32, instruction width in bits.
REQ-002 Parameter DEPTH, default 2, issue-queue entries; power of two, minimum 2.
REQ-003 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 instr_i  input  WIDTH  decoded FPU instruction from the decode stage.
REQ-006 instr_valid_i  input  1  instr_i is valid this cycle.
REQ-007 instr_ready_o  output  1  queue can accept instr_i this cycle.
REQ-008 flush_i  input  1  discard all queued instructions; pipeline redirect.
REQ-009 hazard_i  input  1  RAW hazard on fpu_instr_o, from the downstream FPU hazard unit; same cycle.
REQ-010 fpu_instr_o  output  WIDTH  queue head, presented to the hazard unit and the FPU.
REQ-011 execute_o  output  1  head issues to the FPU this cycle.
REQ-012 stall_o  output  1  head valid but blocked by hazard_i.
REQ-013 stall_count_o  output  16  stall-cycle counter; present only with FPU_ISSUE_STATS_EN.

Function
REQ-014 Instructions SHALL be held in a DEPTH-entry FIFO with read pointer, write pointer and occupancy count; pointers wrap modulo DEPTH.
REQ-015 fpu_instr_o SHALL be the head entry combinationally when the queue is non-empty, and all-zero when it is empty.
REQ-016 instr_ready_o SHALL equal (count != DEPTH); it SHALL depend on registered state only, with no combinational path from hazard_i or flush_i.
REQ-017 A push SHALL occur when instr_valid_i && instr_ready_o && !flush_i.
REQ-018 execute_o SHALL equal (count != 0) && !hazard_i && !flush_i.
REQ-019 A pop SHALL occur exactly when execute_o is 1.
REQ-020 stall_o SHALL equal (count != 0) && hazard_i && !flush_i.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-022 Empty queue: a pushed instruction is not visible on fpu_instr_o until the next cycle (minimum latency 1 cycle, no bypass).
REQ-023 Full queue: instr_ready_o is 0 and instr_i is ignored, even if a pop occurs in the same cycle.
REQ-024 flush_i SHALL zero count and both pointers on the next edge; execute_o is 0 and any push is dropped during the flush cycle.
REQ-025 FIFO order SHALL be preserved; a stalled head SHALL NOT be bypassed by younger entries.
REQ-026 hazard_i SHALL be ignored while the queue is empty.

Reset
REQ-027 While rst_i is high at an edge, count and both pointers SHALL be cleared, and stall_count_o SHALL be cleared when present.
REQ-028 After reset: instr_ready_o=1, execute_o=0, stall_o=0, fpu_instr_o=0.
REQ-029 Reset SHALL take priority over flush_i, push and pop in the same cycle.
REQ-030 Reset asserted mid-stall SHALL discard all queued entries with no issue.

Configuration
REQ-031 With FPU_ISSUE_STATS_EN defined: stall_count_o is present and increments by 1 on each edge where stall_o=1, saturates at 16'hFFFF, and clears only on reset.
REQ-032 Without FPU_ISSUE_STATS_EN: the stall_count_o port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset, then push 0x0000_1234 with hazard_i=0 -> next cycle fpu_instr_o=0x0000_1234 and execute_o=1; the following cycle execute_o=0 and fpu_instr_o=0.
REQ-034 Push A, B, C on back-to-back cycles with hazard_i=1 -> instr_ready_o drops to 0 after A and B; C is held off; stall_o=1 with head=A; release hazard_i -> A then B issue on consecutive cycles.
REQ-035 Full queue with hazard_i=0 and instr_valid_i held -> one pop per cycle; new pushes are accepted only on cycles when ready was 1; issue order matches push order.
REQ-036 Two entries queued, flush_i=1 while also pushing D -> execute_o=0 that cycle; next cycle count=0 and fpu_instr_o=0; D is never issued.
REQ-037 With FPU_ISSUE_STATS_EN: hold hazard_i=1 for 70000 cycles with a valid head -> stall_count_o=16'hFFFF; assert rst_i -> stall_count_o=0.
REQ-038 rst_i and flush_i asserted together while pushing -> all outputs return to their reset values (REQ-028) the next cycle.
